// File: rtl/z_core_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : z_core_div_unit_if
// Brief    : Start/done handshake and operand/result bundle for the Z-Core
//            iterative divider. The master issues operations; the slave is the
//            divider itself.
// Revision : 1.0  initial release
// ============================================================================
interface z_core_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            div_signed;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport master (
    output start, op1, op2, div_signed,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, op1, op2, div_signed,
    output busy, done, quotient, remainder
  );
endinterface
`default_nettype wire

// File: rtl/z_core_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : z_core_div_unit
// Brief    : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
//            Operands are reduced to magnitudes on the start edge, XLEN
//            restoring steps produce the unsigned quotient and remainder, and a
//            final cycle restores the signs. Divide-by-zero and signed
//            overflow skip the iteration and finish one edge after start.
// Revision : 1.0  initial release
// ============================================================================
module z_core_div_unit #(
  parameter int XLEN = 32
) (
  input  wire logic        clk,
  input  wire logic        rstn,
  z_core_div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  c_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_dvd;      // dividend shifting out, quotient shifting in
  logic [XLEN-1:0]  r_rem;      // partial remainder (unsigned magnitude)
  logic [XLEN-1:0]  r_dvs;      // divisor magnitude
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_special;  // result already final, skip sign correction
  logic             r_busy;
  logic             r_done;
  logic [XLEN-1:0]  r_quotient;
  logic [XLEN-1:0]  r_remainder;

  logic             w_op1_neg;
  logic             w_op2_neg;
  logic [XLEN-1:0]  w_mag1;
  logic [XLEN-1:0]  w_mag2;
  logic             w_div_zero;
  logic             w_overflow;
  logic [XLEN:0]    w_shift;
  logic [XLEN:0]    w_trial;
  logic             w_fits;
  logic [XLEN-1:0]  w_q_fix;
  logic [XLEN-1:0]  w_r_fix;

  assign w_op1_neg  = bus.div_signed & bus.op1[XLEN-1];
  assign w_op2_neg  = bus.div_signed & bus.op2[XLEN-1];
  assign w_mag1     = w_op1_neg ? -bus.op1 : bus.op1;
  assign w_mag2     = w_op2_neg ? -bus.op2 : bus.op2;
  assign w_div_zero = (bus.op2 == '0);
  assign w_overflow = bus.div_signed && (bus.op1 == c_MIN_NEG) && (bus.op2 == '1);

  // The shifted partial remainder keeps its top bit: with an unsigned divisor
  // above 2^(XLEN-1) the remainder itself can have its MSB set, so the trial
  // subtraction is carried out one bit wider than the operands.
  assign w_shift = {r_rem, r_dvd[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_fits  = ~w_trial[XLEN];

  assign w_q_fix = (r_q_neg && !r_special) ? -r_dvd : r_dvd;
  assign w_r_fix = (r_r_neg && !r_special) ? -r_rem : r_rem;

  // Control FSM plus datapath: capture, restoring iteration, sign fix-up.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= c_IDLE;
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_rem       <= '0;
      r_dvs       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_special   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (bus.start) begin
            r_busy  <= 1'b1;
            r_q_neg <= w_op1_neg ^ w_op2_neg;
            r_r_neg <= w_op1_neg;
            r_dvs   <= w_mag2;
            if (w_div_zero) begin
              r_dvd     <= '1;
              r_rem     <= bus.op1;
              r_special <= 1'b1;
              r_state   <= c_FIX;
            end else if (w_overflow) begin
              r_dvd     <= bus.op1;
              r_rem     <= '0;
              r_special <= 1'b1;
              r_state   <= c_FIX;
            end else begin
              r_dvd     <= w_mag1;
              r_rem     <= '0;
              r_special <= 1'b0;
              r_cnt     <= c_CNT_LAST;
              r_state   <= c_CALC;
            end
          end
        end
        c_CALC: begin
          r_dvd <= {r_dvd[XLEN-2:0], w_fits};
          r_rem <= w_fits ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
          r_cnt <= r_cnt - c_CNT_ONE;
          if (r_cnt == '0) begin
            r_state <= c_FIX;
          end
        end
        c_FIX: begin
          r_quotient  <= w_q_fix;
          r_remainder <= w_r_fix;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;

endmodule
`default_nettype wire

// File: tb/tb_z_core_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_z_core_div_unit
// Brief    : Self-checking bench for z_core_div_unit: directed vector table,
//            multi-cycle corner sequences and a randomized sweep against a
//            plain-arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_z_core_div_unit;

  logic clk;
  logic rstn;
  int   cyc;
  int   c0;
  int   total;
  int   bad;

  z_core_div_unit_if #(.XLEN(32)) bus ();

  z_core_div_unit #(.XLEN(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // free-running edge counter used to measure latency
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        sgn;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    int          exp_lat;
  } vec_t;

  vec_t tbl [10];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference: RISC-V division semantics computed with 64-bit integer math.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else begin
      sa = s ? longint'($signed(a)) : longint'({32'd0, a});
      sb = s ? longint'($signed(b)) : longint'({32'd0, b});
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end
  endfunction

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.op1        = a;
    bus.op2        = b;
    bus.div_signed = s;
    @(posedge clk);
    #1;
    c0             = cyc;
    bus.start      = 1'b0;
    bus.op1        = $urandom;
    bus.op2        = $urandom;
    bus.div_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int lat, output int bc);
    bc  = bus.busy ? 1 : 0;
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = cyc - c0;
        break;
      end
      if (bus.busy) bc++;
    end
  endtask

  initial begin
    int          lat;
    int          bc;
    int          dcnt;
    logic [31:0] a, b, mq, mr, prod;
    logic        s;
    longint      ar, ab;

    total = 0;
    bad   = 0;
    cyc   = 0;
    c0    = 0;

    tbl[0] = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         33};
    tbl[1] = '{32'hFFFFFFF9,  32'h00000002,  1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF,  33};
    tbl[2] = '{32'h00000007,  32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD,  32'h00000001,  33};
    tbl[3] = '{32'h00001234,  32'h00000000,  1'b1, 32'hFFFFFFFF,  32'h00001234,  1};
    tbl[4] = '{32'h00001234,  32'h00000000,  1'b0, 32'hFFFFFFFF,  32'h00001234,  1};
    tbl[5] = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'h00000000,  1};
    tbl[6] = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 32'h00000000,  32'h80000000,  33};
    tbl[7] = '{32'hFFFFFFFF,  32'h80000001,  1'b0, 32'h00000001,  32'h7FFFFFFE,  33};
    tbl[8] = '{32'hFFFFFF9C,  32'hFFFFFFF9,  1'b1, 32'h0000000E,  32'hFFFFFFFE,  33};
    tbl[9] = '{32'h00000000,  32'h00000005,  1'b1, 32'h00000000,  32'h00000000,  33};

    // reset state
    rstn           = 1'b0;
    bus.start      = 1'b0;
    bus.op1        = '0;
    bus.op2        = '0;
    bus.div_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_int("rst_busy", int'(bus.busy), 0);
    check_int("rst_done", int'(bus.done), 0);
    check32("rst_q", bus.quotient, 32'd0);
    check32("rst_r", bus.remainder, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // directed vector table
    for (int i = 0; i < 10; i++) begin
      launch(tbl[i].op1, tbl[i].op2, tbl[i].sgn);
      wait_done(lat, bc);
      check32($sformatf("vec%0d_q", i), bus.quotient, tbl[i].exp_q);
      check32($sformatf("vec%0d_r", i), bus.remainder, tbl[i].exp_r);
      check_int($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
      check_int($sformatf("vec%0d_busy", i), bc, tbl[i].exp_lat);
      @(posedge clk);
      #1;
      check_int($sformatf("vec%0d_done_drop", i), int'(bus.done), 0);
      check32($sformatf("vec%0d_q_hold", i), bus.quotient, tbl[i].exp_q);
    end

    // start pulsed mid-operation must be ignored
    launch(32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op1   = 32'd5;
    bus.op2   = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat, bc);
    check32("midstart_q", bus.quotient, 32'd333);
    check32("midstart_r", bus.remainder, 32'd1);
    check_int("midstart_lat", lat, 33);

    // asynchronous reset mid-CALC
    launch(32'd50000, 32'd9, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_int("abort_busy", int'(bus.busy), 0);
    check_int("abort_done", int'(bus.done), 0);
    check32("abort_q", bus.quotient, 32'd0);
    check32("abort_r", bus.remainder, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dcnt++;
    end
    check_int("abort_no_done", dcnt, 0);

    // fresh operation after the abort
    launch(32'd50000, 32'd9, 1'b0);
    wait_done(lat, bc);
    check32("fresh_q", bus.quotient, 32'd5555);
    check32("fresh_r", bus.remainder, 32'd5);
    check_int("fresh_lat", lat, 33);

    // randomized sweep against the reference model
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == 32'd0) b = 32'd1;
      s = 1'($urandom_range(0, 1));
      launch(a, b, s);
      wait_done(lat, bc);
      ref_div(a, b, s, mq, mr);
      check32($sformatf("rnd%0d_q a=%h b=%h s=%0d", i, a, b, s), bus.quotient, mq);
      check32($sformatf("rnd%0d_r a=%h b=%h s=%0d", i, a, b, s), bus.remainder, mr);
      check_int($sformatf("rnd%0d_lat", i), lat, 33);
      prod = bus.quotient * b + bus.remainder;
      check32($sformatf("rnd%0d_identity", i), prod, a);
      if (s) begin
        ar = longint'($signed(bus.remainder));
        ab = longint'($signed(b));
      end else begin
        ar = longint'({32'd0, bus.remainder});
        ab = longint'({32'd0, b});
      end
      if (ar < 0) ar = -ar;
      if (ab < 0) ab = -ab;
      check_int($sformatf("rnd%0d_rem_bound", i), (ar < ab) ? 1 : 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
